// File: rtl/puf_race_counter.sv
`default_nettype none
// ============================================================================
// Module   : puf_race_counter
// Brief    : Multi-channel race counter for the delay-PUF response path.
//            Each channel counts tick strobes; the first channel to reach
//            GOAL wins and its index becomes the PUF response. Provides a
//            start/busy/done handshake, tie detection and a race timeout.
// Revision : 1.0 - initial release
// ============================================================================
module puf_race_counter #(
  parameter int NUM_CH  = 2,
  parameter int WIDTH   = 9,
  parameter int GOAL    = 255,
  parameter int TIMEOUT = 4096,
  parameter int TMR_W   = 13,
  parameter int IDX_W   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NUM_CH-1:0]       ch_tick,
  output logic                    busy,
  output logic                    done,
  output logic [IDX_W-1:0]        winner,
  output logic                    tie,
  output logic                    timeout,
  output logic [NUM_CH*WIDTH-1:0] cnt_flat
);

  localparam logic [WIDTH-1:0] C_GOAL     = WIDTH'(GOAL);
  localparam logic [WIDTH-1:0] C_GOAL_M1  = WIDTH'(GOAL - 1);
  localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_cnt     [NUM_CH];
  logic [WIDTH-1:0]   w_cnt_nxt [NUM_CH];
  logic [TMR_W-1:0]   r_timer;
  logic [TMR_W-1:0]   w_timer_nxt;

  logic               r_busy,    w_busy_nxt;
  logic               r_done,    w_done_nxt;
  logic [IDX_W-1:0]   r_winner,  w_winner_nxt;
  logic               r_tie,     w_tie_nxt;
  logic               r_timeout, w_timeout_nxt;

  // Race-control decode
  logic               w_clr;
  logic [NUM_CH-1:0]  w_hit;
  logic               w_win;
  logic               w_multi;
  logic [IDX_W-1:0]   w_first;
  logic               w_tmo;

  // A channel hits when its final tick to GOAL arrives while racing
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_hit
      assign w_hit[gi] = (r_state == S_RUN) && ch_tick[gi] && (r_cnt[gi] == C_GOAL_M1);
    end
  endgenerate

  // Lowest-index priority encode of hits, flagging simultaneous hits as a tie
  always_comb begin
    w_win   = 1'b0;
    w_multi = 1'b0;
    w_first = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_hit[i]) begin
        if (w_win) begin
          w_multi = 1'b1;
        end else begin
          w_first = IDX_W'(i);
        end
        w_win = 1'b1;
      end
    end
  end

  // Timeout only counts when no channel wins on the same edge
  assign w_tmo = (r_state == S_RUN) && (r_timer == C_TMR_LAST) && !w_win;

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_winner_nxt  = r_winner;
    w_tie_nxt     = r_tie;
    w_timeout_nxt = r_timeout;
    w_clr         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt   = S_RUN;
          w_busy_nxt    = 1'b1;
          w_timer_nxt   = '0;
          w_winner_nxt  = '0;
          w_tie_nxt     = 1'b0;
          w_timeout_nxt = 1'b0;
          w_clr         = 1'b1;
        end
      end
      S_RUN: begin
        w_timer_nxt = r_timer + 1'b1;
        if (w_win) begin
          w_state_nxt   = S_DONE;
          w_busy_nxt    = 1'b0;
          w_done_nxt    = 1'b1;
          w_winner_nxt  = w_first;
          w_tie_nxt     = w_multi;
          w_timeout_nxt = 1'b0;
        end else if (w_tmo) begin
          w_state_nxt   = S_DONE;
          w_busy_nxt    = 1'b0;
          w_done_nxt    = 1'b1;
          w_winner_nxt  = '0;
          w_tie_nxt     = 1'b0;
          w_timeout_nxt = 1'b1;
        end
      end
      S_DONE: begin
        // Result pulse lasts one cycle; a start seen here is dropped
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered handshake, result and timer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_winner  <= '0;
      r_tie     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timer   <= w_timer_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_winner  <= w_winner_nxt;
      r_tie     <= w_tie_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // Per-channel saturating counters; only move while racing, frozen otherwise
  generate
    for (genvar gc = 0; gc < NUM_CH; gc++) begin : g_ch
      always_comb begin
        w_cnt_nxt[gc] = r_cnt[gc];
        if (w_clr) begin
          w_cnt_nxt[gc] = '0;
        end else if ((r_state == S_RUN) && ch_tick[gc] && (r_cnt[gc] != C_GOAL)) begin
          w_cnt_nxt[gc] = r_cnt[gc] + 1'b1;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_cnt[gc] <= '0;
        end else begin
          r_cnt[gc] <= w_cnt_nxt[gc];
        end
      end

      assign cnt_flat[gc*WIDTH +: WIDTH] = r_cnt[gc];
    end
  endgenerate

  assign busy    = r_busy;
  assign done    = r_done;
  assign winner  = r_winner;
  assign tie     = r_tie;
  assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_puf_race_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_puf_race_counter
// Brief    : Directed self-checking bench for puf_race_counter
//            (NUM_CH=2, WIDTH=9, GOAL=4, TIMEOUT=20).
// Revision : 1.0 - initial release
// ============================================================================
module tb_puf_race_counter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  ch_tick;
  logic        busy;
  logic        done;
  logic [0:0]  winner;
  logic        tie;
  logic        timeout;
  logic [17:0] cnt_flat;

  int n_checks;
  int n_errors;

  puf_race_counter #(
    .NUM_CH  (2),
    .WIDTH   (9),
    .GOAL    (4),
    .TIMEOUT (20),
    .TMR_W   (13),
    .IDX_W   (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .ch_tick  (ch_tick),
    .busy     (busy),
    .done     (done),
    .winner   (winner),
    .tie      (tie),
    .timeout  (timeout),
    .cnt_flat (cnt_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something never completes
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply a tick pattern for one clock, then sample 1 time unit after the edge
  task automatic step(input logic [1:0] t);
    ch_tick = t;
    @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle start from IDLE; returns in RUN cycle 0 (timer=0)
  task automatic do_start();
    start   = 1'b1;
    ch_tick = 2'b00;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Run a race with a per-mode tick pattern; cyc = RUN cycles until done seen, -1 if never
  task automatic run_race(input int mode, input int max_cyc, output int cyc);
    logic [1:0] t;
    cyc = -1;
    for (int k = 0; k < max_cyc; k++) begin
      case (mode)
        0:       t = 2'b01;
        1:       t = {1'b1, (k % 2 == 0)};
        2:       t = 2'b11;
        3:       t = 2'b00;
        4:       t = (k >= 16) ? 2'b01 : 2'b00;
        default: t = 2'b00;
      endcase
      step(t);
      if (done === 1'b1) begin
        cyc = k + 1;
        break;
      end
    end
    ch_tick = 2'b00;
  endtask

  int cyc;
  int nd;

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    start    = 1'b0;
    ch_tick  = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("rst_busy",    busy,     0);
    check("rst_done",    done,     0);
    check("rst_winner",  winner,   0);
    check("rst_tie",     tie,      0);
    check("rst_timeout", timeout,  0);
    check("rst_cnt",     cnt_flat, 0);
    reset = 1'b0;
    step(2'b11);
    check("idle_ignore_ticks", cnt_flat, 0);

    // 1: ch0 alone wins
    do_start();
    check("t1_busy_run", busy, 1);
    run_race(0, 30, cyc);
    check("t1_latency", cyc,      4);
    check("t1_winner",  winner,   0);
    check("t1_tie",     tie,      0);
    check("t1_timeout", timeout,  0);
    check("t1_cnt",     cnt_flat, {9'd0, 9'd4});
    check("t1_busy",    busy,     0);
    step(2'b11);
    check("t1_done_pulse", done,     0);
    check("t1_cnt_frozen", cnt_flat, {9'd0, 9'd4});

    // 2: ch1 every cycle, ch0 every second cycle; back-to-back start
    do_start();
    run_race(1, 30, cyc);
    check("t2_latency", cyc,      4);
    check("t2_busy",    busy,     0);
    check("t2_winner",  winner,   1);
    check("t2_tie",     tie,      0);
    check("t2_cnt",     cnt_flat, {9'd4, 9'd2});
    step(2'b00);
    check("t2_winner_held", winner, 1);

    // 3: both channels tie
    do_start();
    check("t3_winner_clr", winner, 0);
    run_race(2, 30, cyc);
    check("t3_latency", cyc,      4);
    check("t3_winner",  winner,   0);
    check("t3_tie",     tie,      1);
    check("t3_cnt",     cnt_flat, {9'd4, 9'd4});
    step(2'b00);

    // 4: no ticks -> timeout
    do_start();
    check("t4_tie_clr", tie, 0);
    run_race(3, 40, cyc);
    check("t4_latency", cyc,     20);
    check("t4_timeout", timeout, 1);
    check("t4_winner",  winner,  0);
    check("t4_tie",     tie,     0);
    check("t4_busy",    busy,    0);
    step(2'b00);

    // 5: win on the final timer edge beats timeout
    do_start();
    check("t5_timeout_clr", timeout, 0);
    run_race(4, 40, cyc);
    check("t5_latency", cyc,      20);
    check("t5_timeout", timeout,  0);
    check("t5_winner",  winner,   0);
    check("t5_cnt",     cnt_flat, {9'd0, 9'd4});
    step(2'b00);

    // 6a: reset mid-race
    do_start();
    step(2'b01);
    step(2'b01);
    check("t6_cnt_before", cnt_flat, {9'd0, 9'd2});
    check("t6_busy_before", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_busy_async", busy,     0);
    check("t6_cnt_async",  cnt_flat, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    nd = 0;
    for (int k = 0; k < 5; k++) begin
      step(2'b01);
      if (done === 1'b1) nd++;
    end
    check("t6_no_done", nd,       0);
    check("t6_idle_cnt", cnt_flat, 0);

    // 6b: start during RUN does not restart the race
    do_start();
    step(2'b01);
    start = 1'b1;
    step(2'b01);
    start = 1'b0;
    check("t6_run_start_ign", cnt_flat, {9'd0, 9'd2});
    step(2'b01);
    step(2'b01);
    check("t6_done", done, 1);

    // 6c: start during DONE is dropped
    start = 1'b1;
    step(2'b00);
    start = 1'b0;
    check("t6_done_start_ign", busy, 0);
    step(2'b00);
    check("t6_still_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
